// File: rtl/audio_pkg.sv
// Shared definitions for the tone-code audio path: tone codes, half-period
// table, counter width default and the IDLE/PLAY state encoding.
package audio_pkg;

  localparam int CNT_W_DEFAULT = 18;
  localparam int TABLE_W       = 18;

  localparam logic [3:0] TONE_OFF = 4'h0;
  localparam logic [3:0] TONE_C4  = 4'h1;
  localparam logic [3:0] TONE_CS4 = 4'h2;
  localparam logic [3:0] TONE_D4  = 4'h3;
  localparam logic [3:0] TONE_DS4 = 4'h4;
  localparam logic [3:0] TONE_E4  = 4'h5;
  localparam logic [3:0] TONE_F4  = 4'h6;
  localparam logic [3:0] TONE_FS4 = 4'h7;
  localparam logic [3:0] TONE_G4  = 4'h8;
  localparam logic [3:0] TONE_GS4 = 4'h9;
  localparam logic [3:0] TONE_A4  = 4'hA;
  localparam logic [3:0] TONE_AS4 = 4'hB;
  localparam logic [3:0] TONE_B4  = 4'hC;
  localparam logic [3:0] TONE_C5  = 4'hD;
  localparam logic [3:0] TONE_D5  = 4'hE;
  localparam logic [3:0] TONE_E5  = 4'hF;

  // Half-period in 100 MHz cycles; entry 0 (silence) is never used for timing.
  localparam logic [TABLE_W-1:0] HALF_PERIOD [16] = '{
    18'd0,
    18'd191113, 18'd180388, 18'd170265, 18'd160705, 18'd151685,
    18'd143172, 18'd135139, 18'd127551, 18'd120395, 18'd113636,
    18'd107259, 18'd101239, 18'd95557,  18'd85131,  18'd75843
  };

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } state_t;

endpackage

// File: rtl/tone_period_lut.sv
// Combinational tone-code to half-period lookup with simulation scaling
// and a floor of 2 cycles.
import audio_pkg::*;

module tone_period_lut #(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int SCALE_SHIFT = 0
) (
  input  logic [3:0]       code,
  output logic [CNT_W-1:0] half_period
);

  logic [TABLE_W-1:0] scaled;

  always_comb begin
    scaled = HALF_PERIOD[code] >> SCALE_SHIFT;
    if (scaled < TABLE_W'(2)) begin
      half_period = CNT_W'(2);
    end else begin
      half_period = CNT_W'(scaled);
    end
  end

endmodule

// File: rtl/tone_generator.sv
// Square-wave tone generator; pitch changes and silencing only at full-period
// boundaries. Optional PWM volume control via macro TONE_GEN_VOLUME_EN.
import audio_pkg::*;

module tone_generator #(
  parameter int CNT_W       = CNT_W_DEFAULT,
  parameter int SCALE_SHIFT = 0
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] TONE,
`ifdef TONE_GEN_VOLUME_EN
  input  logic [2:0] VOLUME,
`endif
  output logic       AUDIO,
  output logic       ACTIVE,
  output logic [3:0] TONE_CUR
);

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] half_period;
  logic [CNT_W-1:0] terminal;
  logic             phase;

  tone_period_lut #(
    .CNT_W       (CNT_W),
    .SCALE_SHIFT (SCALE_SHIFT)
  ) u_lut (
    .code        (TONE_CUR),
    .half_period (half_period)
  );

  assign terminal = half_period - CNT_W'(1);

  // TONE is only looked at in IDLE and at the terminal count of the low phase.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state    <= IDLE;
      counter  <= '0;
      phase    <= 1'b0;
      ACTIVE   <= 1'b0;
      TONE_CUR <= TONE_OFF;
    end else begin
      case (state)
        IDLE: begin
          if (TONE != TONE_OFF) begin
            TONE_CUR <= TONE;
            counter  <= '0;
            phase    <= 1'b1;
            ACTIVE   <= 1'b1;
            state    <= PLAY;
          end
        end
        PLAY: begin
          if (counter == terminal) begin
            counter <= '0;
            if (phase) begin
              phase <= 1'b0;
            end else if (TONE == TONE_OFF) begin
              state    <= IDLE;
              ACTIVE   <= 1'b0;
              TONE_CUR <= TONE_OFF;
            end else begin
              TONE_CUR <= TONE;
              phase    <= 1'b1;
            end
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TONE_GEN_VOLUME_EN
  logic [2:0] pwm_cnt;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      pwm_cnt <= 3'd0;
    end else begin
      pwm_cnt <= pwm_cnt + 3'd1;
    end
  end

  assign AUDIO = phase & (pwm_cnt <= VOLUME);
`else
  assign AUDIO = phase;
`endif

endmodule

// File: doc/tone_generator.md
Name: tone_generator

Overview:
Consumer end of the 4-bit tone-code interface. It takes the TONE code driven by the note controller and produces a glitch-free square-wave audio bit at the selected pitch. Code 0 means silence. Pitch changes and silencing take effect only at full-period boundaries, so the speaker never sees a truncated pulse. It sits between the controller's TONE output and the board audio pin.

Parameters:
CNT_W, 18, width of the half-period counter; must hold the largest half-period count of 191113.
SCALE_SHIFT, 0, right shift applied to every table half-period; used to speed up simulation. Effective half-period is clamped to a minimum of 2.

Ports:
CLK  input  1  100 MHz system clock; all logic on its rising edge.
RST_N  input  1  synchronous, active-low reset.
TONE  input  4  requested tone code; 0 = silence, 1-15 = pitch.
AUDIO  output  1  square-wave audio bit.
ACTIVE  output  1  high while a tone is sounding (PLAY state).
TONE_CUR  output  4  code currently sounding; 0 when idle.

Behaviour:
- Reset: when RST_N=0 at a CLK edge, the block enters IDLE and sets counter=0, phase=0, AUDIO=0, ACTIVE=0, TONE_CUR=0. Reset takes effect at that edge even mid-period.
- Half-period table, in cycles at 100 MHz (code:count):
  - 1:191113 (C4), 2:180388, 3:170265, 4:160705, 5:151685, 6:143172, 7:135139, 8:127551
  - 9:120395, A:113636 (A4), B:107259, C:101239, D:95557 (C5), E:85131 (D5), F:75843 (E5)
  - HP = table >> SCALE_SHIFT, then clamped to at least 2.
- IDLE:
  - If TONE=0, stay in IDLE.
  - If TONE!=0, at the next edge latch TONE_CUR=TONE, set counter=0, phase=1, AUDIO=1, ACTIVE=1, and move to PLAY. Latency from sampled TONE to AUDIO rising is 1 cycle.
- PLAY:
  - The counter increments every cycle.
  - At counter==HP(TONE_CUR)-1, the counter wraps to 0 and phase toggles. Each phase therefore lasts exactly HP cycles. AUDIO = phase.
- Boundary rule: TONE is sampled only at the terminal count of the low phase (the end of a full period).
  - TONE==0: go to IDLE. AUDIO stays 0, ACTIVE=0, TONE_CUR=0.
  - TONE!=TONE_CUR: load the new code, set phase=1, and start the new pitch's period immediately.
  - TONE==TONE_CUR: continue unchanged.
- TONE changes between boundaries are ignored. Only the value present at the boundary cycle matters.
- Worst-case silencing delay is one full period, about 3.82 ms for C4.
- Counter arithmetic is unsigned CNT_W bits. Wrap happens only by the compare; natural overflow never occurs.

Optional Feature:
Macro: TONE_GEN_VOLUME_EN.
- Enabled:
  - Adds input VOLUME[2:0] and a free-running 3-bit PWM counter, reset to 0.
  - During the high phase, AUDIO = (pwm_cnt <= VOLUME). VOLUME=7 gives a solid high; VOLUME=0 gives 1/8 duty.
  - The low phase stays 0. VOLUME is sampled every cycle. Period timing is unchanged.
- Disabled: no VOLUME port and AUDIO = phase.

Decomposition:
- Shared package audio_pkg holds:
  - localparams for tone codes 0x0-0xF;
  - the 15-entry half-period constant table;
  - CNT_W default;
  - the IDLE/PLAY state encoding.
- Sub-module tone_period_lut is a combinational code-to-HP lookup applying SCALE_SHIFT and the clamp. It is instantiated once.

Test Plan:
- Reset and start (SCALE_SHIFT=4): hold RST_N=0 for 3 cycles with TONE=0xA.
  - During reset: AUDIO=0, ACTIVE=0, TONE_CUR=0.
  - After release: AUDIO=1 and ACTIVE=1 one cycle later; then 7102 cycles high and 7102 low, repeating.
- Idle hold: TONE=0 for 1000 cycles after reset -> AUDIO=0, ACTIVE=0 throughout.
- Pitch change mid-high-phase: switch TONE 0xA->0x1 at cycle 100 of the high phase.
  - The A4 high and low phases still last 7102 cycles each.
  - Then TONE_CUR=1 and phases of 11944 cycles; no shortened pulse.
- Silence mid-period: TONE 0x6->0x0 during the high phase -> the current period completes, then ACTIVE=0 and AUDIO stays 0.
- Reset mid-tone: RST_N=0 for 1 cycle during the high phase of 0xF -> AUDIO=0, ACTIVE=0, TONE_CUR=0 at that edge; on release with TONE=0xF, restart 1 cycle later.
- With TONE_GEN_VOLUME_EN, VOLUME=3: the high phase shows a repeating 4-high/4-low pattern; VOLUME=7 gives a solid high.
